scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N_CH, default 8, number of input channels (2..64, need not be a power of 2).
REQ-002 Parameter W, default 1, bit width of each channel.
REQ-003 Parameter DWELL, default 4, settle cycles before each auto-scan sample (1..255).
REQ-004 Localparam SW = $clog2(N_CH) SHALL set the select and channel-index width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 i  in  N_CH*W  packed channels; channel k occupies i[k*W +: W].
REQ-008 s  in  SW  manual channel select.
REQ-009 mode  in  1  0 = manual, 1 = auto-scan.
REQ-010 start  in  1  single-cycle request to begin an auto-scan.
REQ-011 o  out  W  registered selected data.
REQ-012 o_valid  out  1  o holds a valid sample.
REQ-013 o_ready  in  1  consumer accepts o when o_valid && o_ready.
REQ-014 ch  out  SW  channel index of the current o.
REQ-015 busy  out  1  auto-scan in progress.
REQ-016 done  out  1  one-cycle pulse when a scan completes.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SETTLE, HOLD.
REQ-018 IDLE, mode=0: o <= i[s], ch <= s, o_valid <= 1; latency is 1 cycle; o_ready is ignored.
REQ-019 If s >= N_CH, o SHALL be 0 and ch SHALL equal s.
REQ-020 IDLE, mode=1, start=0: o and ch hold, o_valid <= 0.
REQ-021 IDLE, mode=1, start=1 -> SETTLE: ch <= 0, dwell counter <= DWELL-1, busy <= 1, o_valid <= 0.
REQ-022 SETTLE: the counter decrements each cycle; at count 0 o <= i[ch], o_valid <= 1, -> HOLD (first sample DWELL cycles after start).
REQ-023 HOLD: o, ch and o_valid SHALL stay stable until o_valid && o_ready.
REQ-024 HOLD handshake, ch < N_CH-1: ch <= ch+1, o_valid <= 0, counter reloads, -> SETTLE.
REQ-025 HOLD handshake, ch = N_CH-1: o_valid <= 0, busy <= 0, done <= 1 for one cycle, -> IDLE (see REQ-031).
REQ-026 start while busy SHALL be ignored; mode and s changes while busy SHALL be ignored until IDLE.
REQ-027 start in the same cycle as the final handshake SHALL be ignored; a new scan needs start while IDLE.
REQ-028 o_ready held high SHALL give one sample per DWELL+1 cycles.

Reset
REQ-029 rst_n=0 at any clock edge, mid-scan included, SHALL force IDLE, o=0, ch=0, o_valid=0, busy=0, done=0, counter=0.
REQ-030 The first cycle after reset release SHALL follow REQ-018 or REQ-020 based on mode.

Configuration
REQ-031 Macro SCAN_MUX_CONT_EN defined: at REQ-025, if mode=1, ch SHALL wrap to 0 and the FSM SHALL go to SETTLE, pulsing done and keeping busy=1; if mode=0, the scan SHALL finish as in REQ-025.
REQ-032 Macro SCAN_MUX_CONT_EN undefined: every scan SHALL end after channel N_CH-1 as in REQ-025.

Structure
REQ-033 Package scan_mux_pkg SHALL hold the state enum (IDLE, SETTLE, HOLD) and the mode constants MODE_MANUAL=0 and MODE_AUTO=1.
REQ-034 The combinational N_CH:1 selector SHALL be sub-module scan_mux_sel, parametrised on N_CH and W, returning 0 for an out-of-range select.

Verification
REQ-035 Defaults, mode=0, i=8'b01110110, s stepped 0..7 one per cycle -> o one cycle later = 0,1,1,0,1,1,1,0; o_valid=1.
REQ-036 mode=1, one-cycle start, o_ready=1, same i -> first o_valid 4 cycles after start; ch 0..7 every 5 cycles; o values as in REQ-035; done pulses once; busy falls with done.
REQ-037 o_ready held low 10 cycles in HOLD on ch=3 -> o and ch stable; advance to ch=4 SETTLE on the cycle after o_ready rises.
REQ-038 rst_n=0 for one cycle while ch=5 -> all outputs reset; no done; a later start rescans from ch=0.
REQ-039 N_CH=5, W=4, mode=0, s=6 -> o=0; auto-scan visits ch 0..4 only.
REQ-040 SCAN_MUX_CONT_EN defined, mode=1 -> ch wraps 7 to 0 with done pulse and busy=1; mode=0 during ch=7 HOLD -> busy falls after the ch=7 handshake.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// ============================================================================
//  Module   : scan_mux_pkg
//  Purpose  : Shared FSM state encoding and mode constants for scan_mux.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam int   CNT_W       = 8;

endpackage

`default_nettype wire

// File: rtl/scan_mux_sel.sv
// ============================================================================
//  Module   : scan_mux_sel
//  Purpose  : Combinational N_CH:1 channel selector; out-of-range select -> 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_mux_sel #(
    parameter int N_CH = 8,
    parameter int W    = 1,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] i_data,
    input  logic [SW-1:0]     i_sel,
    output logic [W-1:0]      o_data
);

    // N_CH need not be a power of two, so unmatched codes fall through to zero.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_sel == SW'(k)) begin
                o_data = i_data[k*W +: W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/scan_mux.sv
// ============================================================================
//  Module   : scan_mux
//  Purpose  : Registered channel mux with manual select and auto-scan FSM.
//             Define SCAN_MUX_CONT_EN for continuous (wrap-around) scanning.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*W-1:0]        i,
    input  logic [$clog2(N_CH)-1:0]  s,
    input  logic                     mode,
    input  logic                     start,
    output logic [W-1:0]             o,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [$clog2(N_CH)-1:0]  ch,
    output logic                     busy,
    output logic                     done
);

    localparam int                SW       = $clog2(N_CH);
    localparam logic [CNT_W-1:0]  c_RELOAD = CNT_W'(DWELL - 1);
    localparam logic [SW-1:0]     c_LAST   = SW'(N_CH - 1);

    state_t            r_state, w_state_nxt;
    logic [W-1:0]      r_o,     w_o_nxt;
    logic [SW-1:0]     r_ch,    w_ch_nxt;
    logic              r_valid, w_valid_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;

    logic [SW-1:0]     w_sel_idx;
    logic [W-1:0]      w_sel_data;
    logic              w_hs;
    logic              w_last;
    logic              w_wrap;

    // Manual mode selects from s; auto-scan samples the channel being scanned.
    assign w_sel_idx = (r_state == IDLE) ? s : r_ch;
    assign w_hs      = r_valid & o_ready;
    assign w_last    = (r_ch == c_LAST);

`ifdef SCAN_MUX_CONT_EN
    assign w_wrap = (mode == MODE_AUTO);
`else
    assign w_wrap = 1'b0;
`endif

    scan_mux_sel #(
        .N_CH (N_CH),
        .W    (W),
        .SW   (SW)
    ) u_sel (
        .i_data (i),
        .i_sel  (w_sel_idx),
        .o_data (w_sel_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_o     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_o     <= w_o_nxt;
            r_ch    <= w_ch_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_o_nxt     = r_o;
        w_ch_nxt    = r_ch;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                case (mode)
                    MODE_MANUAL: begin
                        w_o_nxt     = w_sel_data;
                        w_ch_nxt    = s;
                        w_valid_nxt = 1'b1;
                    end
                    default: begin
                        w_valid_nxt = 1'b0;
                        if (start) begin
                            w_ch_nxt    = '0;
                            w_cnt_nxt   = c_RELOAD;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = SETTLE;
                        end
                    end
                endcase
            end

            SETTLE: begin
                if (r_cnt == '0) begin
                    w_o_nxt     = w_sel_data;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            HOLD: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    if (w_last && !w_wrap) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        // A wrap (continuous scan) still flags scan completion.
                        w_ch_nxt    = w_last ? '0 : r_ch + SW'(1);
                        w_done_nxt  = w_last;
                        w_cnt_nxt   = c_RELOAD;
                        w_state_nxt = SETTLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o       = r_o;
    assign o_valid = r_valid;
    assign ch      = r_ch;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_scan_mux.sv
// ============================================================================
//  Module   : tb_scan_mux
//  Purpose  : Self-checking bench for scan_mux (default and N_CH=5/W=4 builds).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scan_mux;

`ifdef SCAN_MUX_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  iv;
    logic [2:0]  s;
    logic        mode, start, o_ready;
    logic        o, o_valid, busy, done;
    logic [2:0]  ch;

    logic [19:0] i5;
    logic [2:0]  s5;
    logic        mode5, start5, rdy5;
    logic [3:0]  o5;
    logic        valid5, busy5, done5;
    logic [2:0]  ch5;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    scan_mux dut (
        .clk(clk), .rst_n(rst_n), .i(iv), .s(s), .mode(mode), .start(start),
        .o(o), .o_valid(o_valid), .o_ready(o_ready), .ch(ch), .busy(busy), .done(done)
    );

    scan_mux #(.N_CH(5), .W(4), .DWELL(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .i(i5), .s(s5), .mode(mode5), .start(start5),
        .o(o5), .o_valid(valid5), .o_ready(rdy5), .ch(ch5), .busy(busy5), .done(done5)
    );

    typedef struct {
        logic [7:0] i;
        logic [2:0] s;
        logic       exp_o;
    } man_vec_t;

    man_vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        bit         found;
        int         n;
        logic [3:0] exp5 [5];

        vecs[0]  = '{8'b01110110, 3'd0, 1'b0};
        vecs[1]  = '{8'b01110110, 3'd1, 1'b1};
        vecs[2]  = '{8'b01110110, 3'd2, 1'b1};
        vecs[3]  = '{8'b01110110, 3'd3, 1'b0};
        vecs[4]  = '{8'b01110110, 3'd4, 1'b1};
        vecs[5]  = '{8'b01110110, 3'd5, 1'b1};
        vecs[6]  = '{8'b01110110, 3'd6, 1'b1};
        vecs[7]  = '{8'b01110110, 3'd7, 1'b0};
        vecs[8]  = '{8'hA5, 3'd0, 1'b1};
        vecs[9]  = '{8'hA5, 3'd1, 1'b0};
        vecs[10] = '{8'hA5, 3'd6, 1'b0};
        vecs[11] = '{8'hA5, 3'd7, 1'b1};

        rst_n = 1'b0; iv = 8'b01110110; s = 3'd0; mode = 1'b0; start = 1'b0; o_ready = 1'b0;
        i5 = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA}; s5 = 3'd0; mode5 = 1'b0; start5 = 1'b0; rdy5 = 1'b0;
        exp5[0] = 4'hA; exp5[1] = 4'hB; exp5[2] = 4'hC; exp5[3] = 4'hD; exp5[4] = 4'hE;

        // Reset state
        tick(); tick();
        chk("rst_o", o, 0);
        chk("rst_ch", ch, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // First cycle after release follows manual mode
        rst_n = 1'b1; s = 3'd2;
        tick();
        chk("post_rst_o", o, 1);
        chk("post_rst_ch", ch, 2);
        chk("post_rst_valid", o_valid, 1);

        // Manual-mode vectors; o_ready toggled to show it is ignored
        for (int k = 0; k < 12; k++) begin
            iv = vecs[k].i; s = vecs[k].s; o_ready = vecs[k].s[0];
            tick();
            chk($sformatf("man%0d_o", k), o, vecs[k].exp_o);
            chk($sformatf("man%0d_ch", k), ch, vecs[k].s);
            chk($sformatf("man%0d_valid", k), o_valid, 1);
        end

        // Auto mode without start: o/ch hold, valid drops
        iv = 8'b01110110; mode = 1'b1; s = 3'd3;
        tick();
        chk("auto_idle_o", o, 1);
        chk("auto_idle_ch", ch, 7);
        chk("auto_idle_valid", o_valid, 0);
        chk("auto_idle_busy", busy, 0);

        // Full scan with o_ready high; stray start/mode activity while busy
        start = 1'b1; o_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("scan_start_busy", busy, 1);
        chk("scan_start_ch", ch, 0);
        chk("scan_start_valid", o_valid, 0);
        for (int t = 1; t <= 43; t++) begin
            logic       ev;
            logic [2:0] ech;
            start = (t == 12 || t == 40);
            mode  = (t >= 20 && t <= 22) ? 1'b0 : 1'b1;
            tick();
            ev  = (t >= 4) && ((t - 4) % 5 == 0) && ((t - 4) / 5 < 8);
            if (t < 5)        ech = 3'd0;
            else if (t >= 40) ech = CONT ? 3'd0 : 3'd7;
            else              ech = 3'((t - 5) / 5 + 1);
            chk($sformatf("scan_t%0d_valid", t), o_valid, ev);
            chk($sformatf("scan_t%0d_ch", t), ch, ech);
            chk($sformatf("scan_t%0d_busy", t), busy, CONT ? 1'b1 : (t < 40));
            chk($sformatf("scan_t%0d_done", t), done, (t == 40));
            if (ev) chk($sformatf("scan_t%0d_o", t), o, iv[(t - 4) / 5]);
        end
        start = 1'b0;

        // Stall in HOLD on ch=3
        iv = 8'h08; start = 1'b1; o_ready = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            if (o_valid && ch == 3'd3) found = 1'b1;
            else tick();
        end
        o_ready = 1'b0;
        chk("stall_reach_ch3", found, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("stall%0d_o", k), o, 1);
            chk($sformatf("stall%0d_ch", k), ch, 3);
            chk($sformatf("stall%0d_valid", k), o_valid, 1);
        end
        o_ready = 1'b1;
        tick();
        chk("stall_adv_ch", ch, 4);
        chk("stall_adv_valid", o_valid, 0);
        chk("stall_adv_busy", busy, 1);

        // Reset mid-scan at ch=5
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (ch == 3'd5) found = 1'b1;
            else tick();
        end
        chk("reach_ch5", found, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_o", o, 0);
        chk("midrst_ch", ch, 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst_n = 1'b1; mode = 1'b1; iv = 8'hFF; o_ready = 1'b0;
        tick();
        chk("after_rst_valid", o_valid, 0);
        chk("after_rst_ch", ch, 0);
        chk("after_rst_busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("no_done%0d", k), {busy, done}, 2'b00);
        end

        // Rescan starts again from ch=0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("rescan_wait%0d_valid", k), o_valid, 0);
        end
        tick();
        chk("rescan_valid", o_valid, 1);
        chk("rescan_ch", ch, 0);
        chk("rescan_o", o, 1);

        // End of scan: finish (default) or wrap (continuous build)
        o_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (done) found = 1'b1;
        end
        chk("end_done_seen", found, 1);
        if (CONT) begin
            chk("wrap_busy", busy, 1);
            chk("wrap_ch", ch, 0);
            chk("wrap_valid", o_valid, 0);
            mode = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 100 && !found; k++) begin
                tick();
                if (done) found = 1'b1;
            end
            chk("cont_stop_done_seen", found, 1);
            chk("cont_stop_busy", busy, 0);
            chk("cont_stop_ch", ch, 7);
        end else begin
            chk("end_busy", busy, 0);
            chk("end_ch", ch, 7);
            chk("end_valid", o_valid, 0);
        end
        tick();
        chk("end_done_pulse", done, 0);
        chk("end_busy_after", busy, 0);

        // N_CH=5, W=4 instance: manual boundaries then auto-scan
        mode5 = 1'b0;
        s5 = 3'd4; tick();
        chk("n5_s4_o", o5, 4'hE);
        chk("n5_s4_ch", ch5, 4);
        s5 = 3'd6; tick();
        chk("n5_s6_o", o5, 0);
        chk("n5_s6_ch", ch5, 6);
        chk("n5_s6_valid", valid5, 1);
        s5 = 3'd5; tick();
        chk("n5_s5_o", o5, 0);
        s5 = 3'd0; tick();
        chk("n5_s0_o", o5, 4'hA);

        mode5 = 1'b1; start5 = 1'b1; rdy5 = 1'b1;
        tick();
        start5 = 1'b0; mode5 = 1'b0;
        n = 0; found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (valid5) begin
                if (n < 5) begin
                    chk($sformatf("n5_scan%0d_ch", n), ch5, n);
                    chk($sformatf("n5_scan%0d_o", n), o5, exp5[n]);
                end else begin
                    chk("n5_extra_sample_ch", ch5, 3'd7);
                end
                n++;
            end
            if (done5) found = 1'b1;
        end
        chk("n5_done_seen", found, 1);
        chk("n5_sample_count", n, 5);
        chk("n5_busy_end", busy5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
